// File: rtl/pl_cp0_exc_pkg.sv
// pl_cp0_exc_pkg: shared CP0 register numbers, exception codes, bit positions
// and the exception-mode encoding used by the CP0 exception controller.
package pl_cp0_exc_pkg;

    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_0080;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_IP7  = 15;

    typedef enum logic {
        MODE_NORMAL    = 1'b0,
        MODE_EXCEPTION = 1'b1
    } cp0_mode_e;

endpackage

// File: rtl/pl_cp0_exc_if.sv
// pl_cp0_exc_if: pipeline <-> CP0 exception controller signals.
// master = pipeline side, slave = CP0 side.
interface pl_cp0_exc_if;
    logic        ex_valid;
    logic        ex_ovf_chk;
    logic        ex_overflow;
    logic [31:0] ex_pc;
    logic        mem_mtc0;
    logic        mem_eret;
    logic [4:0]  mem_cp0_addr;
    logic [31:0] mem_cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        exc_flush;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [31:0] epc;

    modport master (
        output ex_valid, ex_ovf_chk, ex_overflow, ex_pc,
        output mem_mtc0, mem_eret, mem_cp0_addr, mem_cp0_wdata,
        input  cp0_rdata, exc_flush, pc_redirect, pc_target, epc
    );

    modport slave (
        input  ex_valid, ex_ovf_chk, ex_overflow, ex_pc,
        input  mem_mtc0, mem_eret, mem_cp0_addr, mem_cp0_wdata,
        output cp0_rdata, exc_flush, pc_redirect, pc_target, epc
    );
endinterface

// File: rtl/pl_cp0_timer.sv
// pl_cp0_timer: free-running Count, Compare and the IP7 timer-interrupt flag.
// Only instantiated when CP0_TIMER_EN is defined.
module pl_cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ip7
);

    // Count ticks every cycle; a Compare write acknowledges (clears) IP7.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            compare <= 32'hFFFF_FFFF;
            ip7     <= 1'b0;
        end else begin
            count <= wr_count ? wdata : count + 32'd1;
            if (wr_compare) begin
                compare <= wdata;
                ip7     <= 1'b0;
            end else if (count == compare) begin
                ip7 <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pl_cp0_exc.sv
// pl_cp0_exc: CP0 exception controller (Status/Cause/EPC, overflow and timer
// traps, eret). Optional timer build selected by macro CP0_TIMER_EN.
//
//   state          | meaning
//   MODE_NORMAL    | EXL=0, traps are taken and EPC is captured
//   MODE_EXCEPTION | EXL=1, in handler; interrupts masked, EPC preserved
module pl_cp0_exc
    import pl_cp0_exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    pl_cp0_exc_if.slave bus
);

    cp0_mode_e   mode;
    logic        ie;
    logic [4:0]  exc_code;
    logic [31:0] epc_q;
    logic        hold;
    logic        exl;
    logic        ip7;
    logic        eret_take;
    logic        int_take;
    logic        ovf_take;
    logic        trap;
    logic        redirect;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;
    logic [31:0] rdata;

    assign exl = (mode == MODE_EXCEPTION);

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;

    pl_cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .wr_count   (bus.mem_mtc0 && bus.mem_cp0_addr == CP0_REG_COUNT),
        .wr_compare (bus.mem_mtc0 && bus.mem_cp0_addr == CP0_REG_COMPARE),
        .wdata      (bus.mem_cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ip7        (ip7)
    );
`else
    // Without the timer IP7 is just a software-set pending bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ip7 <= 1'b0;
        else if (bus.mem_mtc0 && bus.mem_cp0_addr == CP0_REG_CAUSE)
            ip7 <= bus.mem_cp0_wdata[CAUSE_IP7];
    end
`endif

    // Trap/eret arbitration: eret beats interrupt beats overflow; hold blocks all.
    always_comb begin
        eret_take = bus.mem_eret & ~hold & ~rst;
        int_take  = bus.ex_valid & ie & ~exl & ip7 & ~hold & ~eret_take & ~rst;
        ovf_take  = bus.ex_valid & bus.ex_ovf_chk & bus.ex_overflow & ~hold
                  & ~eret_take & ~int_take & ~rst;
        trap      = int_take | ovf_take;
        redirect  = trap | eret_take;
    end

    // Mode FSM plus CP0 registers; mtc0 commits first, then a trap overrides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode     <= MODE_NORMAL;
            ie       <= 1'b0;
            exc_code <= '0;
            epc_q    <= '0;
            hold     <= 1'b0;
        end else begin
            hold <= redirect;
            if (bus.mem_mtc0) begin
                case (bus.mem_cp0_addr)
                    CP0_REG_STATUS: begin
                        ie   <= bus.mem_cp0_wdata[STATUS_IE];
                        mode <= bus.mem_cp0_wdata[STATUS_EXL] ? MODE_EXCEPTION : MODE_NORMAL;
                    end
                    CP0_REG_EPC: epc_q <= bus.mem_cp0_wdata;
                    default: ;
                endcase
            end
            if (trap) begin
                mode     <= MODE_EXCEPTION;
                exc_code <= int_take ? EXC_INT : EXC_OV;
                if (!exl)
                    epc_q <= bus.ex_pc;
            end else if (eret_take) begin
                mode <= MODE_NORMAL;
            end
        end
    end

    // Combinational mfc0 read mux; everything reads 0 while in reset.
    always_comb begin
        status_rd = 32'd0;
        status_rd[STATUS_IE]  = ie;
        status_rd[STATUS_EXL] = exl;
        cause_rd = 32'd0;
        cause_rd[CAUSE_IP7] = ip7;
        cause_rd[6:2]       = exc_code;
        case (bus.mem_cp0_addr)
            CP0_REG_STATUS:  rdata = status_rd;
            CP0_REG_CAUSE:   rdata = cause_rd;
            CP0_REG_EPC:     rdata = epc_q;
`ifdef CP0_TIMER_EN
            CP0_REG_COUNT:   rdata = count;
            CP0_REG_COMPARE: rdata = compare;
`endif
            default:         rdata = 32'd0;
        endcase
        if (rst)
            rdata = 32'd0;
    end

    assign bus.cp0_rdata   = rdata;
    assign bus.exc_flush   = redirect;
    assign bus.pc_redirect = redirect;
    assign bus.pc_target   = eret_take ? epc_q : (trap ? HANDLER_ADDR : 32'd0);
    assign bus.epc         = epc_q;

endmodule
